// File: rtl/key_event_queue.sv
// key_event_queue: round-robin key change scanner feeding a first-word-fall-through event FIFO
// Ports: clk_i/rst_n_i clock and async active-low reset; keys_i debounced levels (1 = pressed);
// evt_valid_o/evt_ready_i/evt_data_o head event handshake, data = {pressed, key index};
// evt_count_o queued entries; overflow_o sticky deferred-change flag, cleared by overflow_clr_i.
module key_event_queue #(
  parameter int KEYS = 61,
  parameter int IDX_W = 6,
  parameter int DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [KEYS-1:0]              keys_i,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [IDX_W:0]               evt_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   evt_count_o,
  output logic                         overflow_o,
  input  logic                         overflow_clr_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {PRIME, SCAN} state_t;
  state_t state;
  logic [KEYS-1:0] reported;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic full, chg, push, pop;
  assign full = evt_count_o == CW'(DEPTH);
  assign chg = state == SCAN && keys_i[idx] != reported[idx];
  assign push = chg && !full;
  assign evt_valid_o = evt_count_o != '0;
  assign pop = evt_valid_o && evt_ready_i;
  assign evt_data_o = mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= PRIME;
      reported <= '0;
      idx <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      evt_count_o <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= SCAN;
      // first cycle after reset adopts current levels so held keys never report
      if (state == PRIME) reported <= keys_i;
      else begin
        idx <= idx == IDX_W'(KEYS - 1) ? '0 : idx + 1'b1;
        // a change blocked by a full FIFO leaves reported[] stale, so it is retried next pass
        if (push) reported[idx] <= keys_i[idx];
      end
      if (push) begin
        mem[wr_ptr] <= {keys_i[idx], idx};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      evt_count_o <= evt_count_o + CW'(push) - CW'(pop);
      overflow_o <= (chg && full) || (overflow_o && !overflow_clr_i);
    end
endmodule
